// File: rtl/uart_tx_serializer.sv
// UART transmitter: 8N1 frame on a rising edge of tx_start, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module uart_tx_serializer #(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_line,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          start_q;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  logic bit_end;
  logic start_rise;

  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign start_rise = tx_start & ~start_q;

  // NOTE: every register here updates with <= so all reads in this block see
  // pre-edge values; blocking assignments would make results order-dependent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      // A start level already high when reset releases must drop before it counts.
      start_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
      tx_line    <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      start_q <= tx_start;
      tx_done <= 1'b0;

      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          if (start_rise) begin
            shreg      <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
            baud_cnt   <= '0;
            tx_line    <= 1'b0;
            tx_busy    <= 1'b1;
            state      <= START;
          end
        end

        START: begin
          if (bit_end) begin
            tx_line <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= '0;
            state   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_line <= parity_bit;
              state   <= PARITY;
`else
              tx_line <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              tx_line <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx_line <= 1'b1;
            state   <= STOP;
          end
        end
`endif

        STOP: begin
          // Edges arriving here, including on this final edge, are dropped.
          if (bit_end) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at 10 clocks per bit; a queue holds
// the expected line bits of each frame as it is launched.
module tb_uart_tx_serializer;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_start = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_line;
  logic       tx_busy;
  logic       tx_done;

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_q[$];

  uart_tx_serializer #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD       (100_000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_line (tx_line),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^d);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Launch a frame and watch it to the tx_done sample (j == FL).
  // raise_j: sample after which tx_start is driven high with raise_d.
  task automatic run_frame(input logic [7:0] d, input bit hold,
                           input int raise_j, input logic [7:0] raise_d);
    logic cur;
    int   dones;
    cur   = 1'bx;
    dones = 0;
    tx_data  = d;
    tx_start = 1'b1;
    push_frame(d);
    tick();
    for (int j = 0; j <= FL; j++) begin
      if (j < FL) begin
        if (j % CPB == 0) cur = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        check($sformatf("line_%02h_c%0d", d, j), tx_line, cur);
        check($sformatf("busy_%02h_c%0d", d, j), tx_busy, 1'b1);
      end else begin
        check($sformatf("end_line_%02h", d), tx_line, 1'b1);
        check($sformatf("end_busy_%02h", d), tx_busy, 1'b0);
        check($sformatf("end_done_%02h", d), tx_done, 1'b1);
      end
      if (tx_done) dones++;
      if (j == 0 && !hold) tx_start = 1'b0;
      if (j == raise_j) begin
        tx_data  = raise_d;
        tx_start = 1'b1;
      end
      if (j < FL) tick();
    end
    check($sformatf("done_pulses_%02h", d), 8'(dones), 8'd1);
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check($sformatf("%s_busy_%0d", tag, i), tx_busy, 1'b0);
      check($sformatf("%s_line_%0d", tag, i), tx_line, 1'b1);
    end
  endtask

  initial begin
    // Reset with tx_start already high: no frame until it drops and rises.
    #22;
    check("rst_line", tx_line, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    tick();
    reset_n = 1'b1;
    expect_idle("post_rst_held", 8);
    tx_start = 1'b0;
    tick();

    // Basic frame.
    run_frame(8'h55, 1'b0, -1, 8'h00);

    // Held start: exactly one frame in 500 cycles.
    run_frame(8'hA3, 1'b1, -1, 8'h00);
    expect_idle("held", 500 - FL);
    tx_start = 1'b0;
    tick();

    // Edge while busy, with new data, must be dropped.
    run_frame(8'h0F, 1'b0, 40, 8'hF0);
    expect_idle("busy_edge", 15);
    tx_start = 1'b0;
    tick();

    // Reset at cycle 35 of a frame, asserted between clock edges.
    tx_data  = 8'h5A;
    tx_start = 1'b1;
    tick();
    repeat (35) tick();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_line", tx_line, 1'b1);
    check("midrst_busy", tx_busy, 1'b0);
    check("midrst_done", tx_done, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    expect_idle("midrst_held", 30);
    tx_start = 1'b0;
    tick();
    run_frame(8'h5A, 1'b0, -1, 8'h00);

    // Parity patterns (plain frames when parity is not compiled in).
    run_frame(8'h07, 1'b0, -1, 8'h00);
    run_frame(8'h03, 1'b0, -1, 8'h00);

    // Edge on the tx_done edge itself is ignored.
    run_frame(8'h96, 1'b0, FL - 1, 8'h11);
    expect_idle("done_edge", 20);
    tx_start = 1'b0;
    tick();

    // Back-to-back: edge on the first cycle after tx_done is accepted.
    run_frame(8'hC4, 1'b0, FL, 8'h3B);
    run_frame(8'h3B, 1'b0, -1, 8'h00);
    expect_idle("final", 5);

    check("sb_drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
